concat_packer: RTL
==================

# concat_packer

Packs a stream of concatenated `{a,b}` fields into wide words for downstream storage. Each accepted beat forms one 6-bit field `{a[3:0], b[1:0]}`. NUM_WORDS fields are collected into one output word, first-accepted field in the MSBs. The block sits directly downstream of the concatenation stage. It uses valid/ready on both sides and a flush input that emits a partially filled word.

## Interface

- NUM_WORDS, 4, fields per output word; legal range 2..8
- CW (localparam), $clog2(NUM_WORDS+1), width of out_count

- clk  in  1  rising-edge clock; the block's only clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  a/b hold a valid beat
- in_ready  out  1  block accepts a beat this cycle
- a  in  4  upper 4 bits of the field
- b  in  2  lower 2 bits of the field
- flush  in  1  single-cycle request to emit the current partial word
- out_valid  out  1  out_data/out_count valid
- out_ready  in  1  downstream accepts the word
- out_data  out  6*NUM_WORDS  packed word; field k (k=0 first accepted) at bits [6*(NUM_WORDS-k)-1 -: 6]
- out_count  out  CW  number of valid fields in out_data (1..NUM_WORDS)

## Operation

- Two states: FILL (collecting) and HOLD (word presented).
- Reset (rst=1 at a clk edge) forces the following, regardless of current state or pending handshakes:
  - state=FILL, fill count=0, buffer=0
  - out_valid=0, out_data=0, out_count=0
  - in_ready=1 from the first cycle after reset
- FILL:
  - in_ready=1.
  - Accept = in_valid & in_ready. On accept, `{a,b}` is written to slot `count`, and count increments.
  - If count reaches NUM_WORDS on this accept, go to HOLD with out_count=NUM_WORDS and count reset to 0.
  - flush=1 with count>0 (after including any beat accepted in the same cycle): go to HOLD with out_count=count. Unused low slots read 0. count resets to 0.
  - flush=1 with count=0 and no beat accepted: ignored, no output.
  - flush in the same cycle as the accept that completes a full word: one full word is emitted; the flush is consumed, with no extra empty word.
- HOLD:
  - in_ready=0 and out_valid=1.
  - out_data and out_count stay stable until out_valid & out_ready.
  - On the handshake, return to FILL with buffer cleared to 0 and out_valid=0 on the next cycle.
  - flush in HOLD is ignored.
- No bypass: a new beat is not accepted in the cycle the output handshake fires.
- in_valid may drop at any time without consequence. a/b are sampled only on accept.

## Timing

- All outputs are registered. There is no combinational path from in_valid, a, b, flush or out_ready to any output. in_ready is a decode of the state register.
- Latency: out_valid rises 1 cycle after the clk edge that accepts the final field or samples flush.
- Throughput: best case is one full word every NUM_WORDS+1 cycles (NUM_WORDS fill cycles plus 1 HOLD cycle with out_ready=1).
- Backpressure: with out_ready held low, HOLD persists indefinitely, in_ready stays 0, and no beat is lost or duplicated.
- Reset mid-operation:
  - A partial word in FILL is discarded, with no output.
  - A word pending in HOLD is dropped, and out_valid is 0 the cycle after reset.

## Test plan

- Reset check:
  - Stimulus: hold rst for 2 cycles with in_valid=1.
  - Required: out_valid=0, out_data=0, out_count=0, no accept while rst=1, and in_ready=1 after release.
- Full word:
  - Stimulus: NUM_WORDS=4, out_ready=1; accept (a,b) = (1010,11), (0101,01), (1111,00), (0000,10) on consecutive cycles.
  - Required: out_data=24'hAD5F02 and out_count=4 one cycle after the 4th accept; out_valid high for exactly 1 cycle.
- Backpressure:
  - Stimulus: same 4 beats, out_ready=0 for 5 cycles, then 1.
  - Required: out_data holds 24'hAD5F02; in_ready=0 throughout HOLD; a 5th beat presented during HOLD is not accepted and appears as field 0 of the next word.
- Partial flush:
  - Stimulus: accept (1010,11) and (0101,01), then pulse flush.
  - Required: out_data=24'hAD5000 and out_count=2 the next cycle.
  - Follow-up: flush with count=0 produces no output.
- Flush coincident with accept:
  - Case 1: flush on the 2nd accept cycle. Required: out_count=2, out_data=24'hAD5000.
  - Case 2: flush on the 4th accept cycle. Required: exactly one word, 24'hAD5F02 with out_count=4.
- Reset mid-operation:
  - Case 1: assert rst after 3 accepts, then send 4 fresh beats. Required: the next word contains only the fresh beats.
  - Case 2: assert rst during HOLD. Required: out_valid=0 the next cycle.

Source files
------------

// File: rtl/concat_packer.sv
// concat_packer: packs a stream of 6-bit {a,b} fields into wide words.
// NUM_WORDS fields form one output word; the first accepted field lands in
// the MSBs. A flush request emits a partially filled word with unused low
// slots reading zero.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     input handshake, a[3:0] and b[1:0] form one field
//   flush                 single-cycle request to emit the current partial word
//   out_valid/out_ready   output handshake
//   out_data              packed word, field k at [6*(NUM_WORDS-k)-1 -: 6]
//   out_count             number of valid fields in out_data (1..NUM_WORDS)
module concat_packer #(
  parameter int NUM_WORDS = 4,
  localparam int CW = $clog2(NUM_WORDS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             a,
  input  logic [1:0]             b,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [6*NUM_WORDS-1:0] out_data,
  output logic [CW-1:0]          out_count
);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt, cnt_inc;
  logic [6*NUM_WORDS-1:0] data_q, data_nxt;
  logic [CW-1:0]          ocnt_q, ocnt_nxt;
  logic                   accept;

  // Handshake flags decode straight from the state register.
  assign in_ready  = (state == FILL);
  assign out_valid = (state == HOLD);
  assign out_data  = data_q;
  assign out_count = ocnt_q;

  assign accept  = in_valid & (state == FILL);
  assign cnt_inc = cnt + CW'(accept);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    data_nxt  = data_q;
    ocnt_nxt  = ocnt_q;
    unique case (state)
      FILL: begin
        // Write the incoming field into slot cnt (slot 0 is the MSB field).
        if (accept) begin
          for (int k = 0; k < NUM_WORDS; k++) begin
            if (cnt == CW'(k)) data_nxt[6*(NUM_WORDS-k)-1 -: 6] = {a, b};
          end
        end
        // A full word takes priority; a coincident flush is absorbed by it.
        if (cnt_inc == CW'(NUM_WORDS)) begin
          state_nxt = HOLD;
          ocnt_nxt  = CW'(NUM_WORDS);
          cnt_nxt   = '0;
        end else if (flush && cnt_inc != '0) begin
          state_nxt = HOLD;
          ocnt_nxt  = cnt_inc;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt_inc;
        end
      end
      HOLD: begin
        // Word stays frozen until taken; flush and input are ignored here.
        if (out_ready) begin
          state_nxt = FILL;
          data_nxt  = '0;
          ocnt_nxt  = '0;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FILL;
      cnt    <= '0;
      data_q <= '0;
      ocnt_q <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      data_q <= data_nxt;
      ocnt_q <= ocnt_nxt;
    end
  end

endmodule
